fxp_iq_scaler: RTL

//   Parametrised complex (I/Q) fixed-point gain stage with valid/ready flow control.

---
 rtl/fxp_iq_scaler.sv | 111 +++++++++++
 1 files changed

// File: rtl/fxp_iq_scaler.sv
// rtl/fxp_iq_scaler.sv - complex I/Q fixed-point gain with rounding/saturation, 2-stage stallable pipeline
// Build option: define FXP_IQ_ROUND_EN for round-half-up; default build truncates (floor).
module fxp_iq_scaler #(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 16,
  parameter int FRAC_W = 15,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [GAIN_W-1:0] gain_in,
  input  logic                     gain_load,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_i,
  input  logic signed [DATA_W-1:0] s_q,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  m_i,
  output logic signed [OUT_W-1:0]  m_q,
  output logic                     sat_flag,
  input  logic                     sat_clr
);

  localparam int PW = DATA_W + GAIN_W;

  // Unity gain, or the largest positive gain when FRAC_W leaves no integer bit.
  localparam logic [GAIN_W-1:0] GAIN_ONE = {{(GAIN_W-1){1'b0}}, 1'b1};
  localparam logic signed [GAIN_W-1:0] GAIN_RST =
    (FRAC_W >= GAIN_W-1) ? {1'b0, {(GAIN_W-1){1'b1}}} : (GAIN_ONE << FRAC_W);

`ifdef FXP_IQ_ROUND_EN
  localparam logic signed [PW:0] BIAS = {{PW{1'b0}}, 1'b1} << (FRAC_W-1);
`else
  localparam logic signed [PW:0] BIAS = '0;
`endif

  localparam logic signed [PW:0] OUT_MAX = {{(PW+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PW:0] OUT_MIN = {{(PW+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [GAIN_W-1:0] gain;
  logic                     v1;
  logic signed [PW-1:0]     p_i;
  logic signed [PW-1:0]     p_q;
  logic                     en1;
  logic                     en2;
  logic signed [OUT_W-1:0]  y_i;
  logic signed [OUT_W-1:0]  y_q;
  logic                     sat_i;
  logic                     sat_q;

  assign en2     = !m_valid || m_ready;
  assign en1     = !v1 || en2;
  assign s_ready = en1;

  // One extra bit above the product keeps the rounding bias from overflowing.
  function automatic logic [OUT_W:0] rescale(input logic signed [PW-1:0] p);
    logic signed [PW:0] r;
    logic signed [PW:0] t;
    r = (PW+1)'(p) + BIAS;
    t = r >>> FRAC_W;
    if (t > OUT_MAX) begin
      rescale = {1'b1, OUT_MAX[OUT_W-1:0]};
    end else if (t < OUT_MIN) begin
      rescale = {1'b1, OUT_MIN[OUT_W-1:0]};
    end else begin
      rescale = {1'b0, t[OUT_W-1:0]};
    end
  endfunction

  assign {sat_i, y_i} = rescale(p_i);
  assign {sat_q, y_q} = rescale(p_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gain     <= GAIN_RST;
      v1       <= 1'b0;
      p_i      <= '0;
      p_q      <= '0;
      m_valid  <= 1'b0;
      m_i      <= '0;
      m_q      <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (gain_load) begin
        gain <= gain_in;
      end
      if (en1) begin
        v1 <= s_valid;
        if (s_valid) begin
          p_i <= PW'(s_i) * PW'(gain);
          p_q <= PW'(s_q) * PW'(gain);
        end
      end
      if (en2) begin
        m_valid <= v1;
        if (v1) begin
          m_i <= y_i;
          m_q <= y_q;
        end
      end
      // A fresh clamp on this edge overrides a simultaneous clear.
      if (en2 && v1 && (sat_i || sat_q)) begin
        sat_flag <= 1'b1;
      end else if (sat_clr) begin
        sat_flag <= 1'b0;
      end
    end
  end

endmodule
